// File: rtl/mant_sum_seq.sv
// mant_sum_seq: sequences the three-input mantissa adder over a stream of
// operand pairs. Each accepted beat folds acc + a + b into a registered
// accumulator. The finished sum and a sticky overflow flag are then offered
// on a result handshake.

module mant_sum_seq #(
    parameter int W     = 26,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_ops,
    input  logic             abort,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_sum,
    output logic             res_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_r;
    logic [W-1:0]     acc_r;
    logic             ovf_r;
    logic [CNT_W-1:0] rem_r;

    logic             beat_s;
    logic             last_s;
    logic [W-1:0]     b_eff_s;
    logic [W+1:0]     t_s;

    // Beat acceptance and the widened three-input sum for the current beat.
    always_comb begin
        beat_s  = 1'b0;
        last_s  = 1'b0;
        b_eff_s = '0;
        t_s     = '0;
        if (state_r == ACC) begin
            beat_s = op_valid & ~abort;
        end else begin
            beat_s = 1'b0;
        end
        last_s = (rem_r <= CNT_W'(2));
        // On the final beat of an odd-length job only op_a counts.
        if (rem_r >= CNT_W'(2)) begin
            b_eff_s = op_b;
        end else begin
            b_eff_s = '0;
        end
        t_s = {2'b00, acc_r} + {2'b00, op_a} + {2'b00, b_eff_s};
    end

    // Status outputs follow directly from the state register; op_ready drops
    // in the abort cycle itself so a cancelled job never swallows a beat.
    always_comb begin
        busy      = (state_r != IDLE);
        res_valid = (state_r == HOLD);
        op_ready  = (state_r == ACC) & ~abort;
        res_sum   = acc_r;
        res_ovf   = ovf_r;
    end

    // Job sequencer: state, accumulator, sticky overflow and remaining count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            rem_r   <= '0;
        end else if (abort) begin
            // Cancel wins over everything else, including a start in IDLE.
            state_r <= IDLE;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            rem_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r <= '0;
                        ovf_r <= 1'b0;
                        rem_r <= n_ops;
                        if (n_ops != '0) begin
                            state_r <= ACC;
                        end else begin
                            // Empty job: go straight to presenting a zero sum.
                            state_r <= HOLD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC: begin
                    if (beat_s) begin
                        acc_r <= t_s[W-1:0];
                        ovf_r <= ovf_r | (t_s[W+1:W] != 2'b00);
                        if (last_s) begin
                            rem_r   <= '0;
                            state_r <= HOLD;
                        end else begin
                            rem_r   <= rem_r - CNT_W'(2);
                            state_r <= ACC;
                        end
                    end else begin
                        state_r <= ACC;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    acc_r   <= '0;
                    ovf_r   <= 1'b0;
                    rem_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_sum_seq.sv
// Testbench for mant_sum_seq: directed jobs whose expected results are pushed
// into a scoreboard at job start and popped by an independent monitor at
// every result handshake.

module tb_mant_sum_seq;

    localparam int W     = 26;
    localparam int CNT_W = 8;
    localparam logic [W-1:0] MAXV = 26'h3FFFFFF;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_ops;
    logic             abort;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic             res_ovf;

    int checks   = 0;
    int failures = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];

    mant_sum_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_ops     (n_ops),
        .abort     (abort),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every result handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_sum), 32'hFFFF_FFFF);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("res_sum", 32'(res_sum), 32'(e[W-1:0]));
                check("res_ovf", 32'(res_ovf), 32'(e[W]));
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, possibly after a gap, and wait (bounded) until taken.
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
        bit done;
        done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            op_valid = 1'b0;
            tick();
        end
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            done = op_ready;
            tick();
        end
        if (!done) check("beat_timeout", 32'd0, 32'd1);
        op_valid = 1'b0;
    endtask

    // Run a job from va/vb; hold>0 keeps res_ready low for that many cycles
    // while pulsing start, which must be ignored.
    task automatic run_job(input int n, input int gap, input int hold,
                           input logic [W-1:0] exp_sum, input logic exp_ovf);
        exp_q.push_back({exp_ovf, exp_sum});
        res_ready = (hold == 0);
        start = 1'b1;
        n_ops = CNT_W'(n);
        tick();
        start = 1'b0;
        n_ops = '0;
        if (n == 0) begin
            check("empty_res_valid_T1", 32'(res_valid), 32'd1);
        end else begin
            check("op_ready_T1", 32'(op_ready), 32'd1);
            for (int i = 0; i < va.size(); i++) send_beat(va[i], vb[i], gap);
            check("res_valid_L1", 32'(res_valid), 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            start = h[0];
            n_ops = CNT_W'(2);
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_sum", 32'(res_sum), 32'(exp_sum));
        end
        // Start in the same cycle as the result handshake is ignored.
        start = (hold != 0);
        n_ops = CNT_W'(2);
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        check("idle_after_result", 32'(busy), 32'd0);
        va.delete();
        vb.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; n_ops = '0; abort = 1'b0;
        op_valid = 1'b1; op_a = '0; op_b = '0; res_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_ovf", 32'(res_ovf), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_op_ready", 32'(op_ready), 32'd0);
        end
        op_valid = 1'b0;

        // 1+2+3+4
        va = '{26'd1, 26'd3}; vb = '{26'd2, 26'd4};
        run_job(4, 0, 0, 26'd10, 1'b0);

        // Odd length: last op_b ignored, 5+7+9
        va = '{26'd5, 26'd9}; vb = '{26'd7, MAXV};
        run_job(3, 0, 0, 26'd21, 1'b0);

        // Empty job
        run_job(0, 0, 0, 26'd0, 1'b0);

        // Overflow then sticky flag cleared by the next start
        va = '{MAXV}; vb = '{MAXV};
        run_job(2, 0, 0, 26'h3FFFFFE, 1'b1);
        va = '{26'd1}; vb = '{26'd1};
        run_job(2, 0, 0, 26'd2, 1'b0);

        // Carry of two out of one step: 4*MAXV wraps to MAXV-3
        va = '{MAXV, MAXV}; vb = '{MAXV, MAXV};
        run_job(4, 0, 0, 26'h3FFFFFC, 1'b1);

        // Stalls on operands and result backpressure with ignored starts
        va = '{26'd100, 26'd300, 26'd500}; vb = '{26'd200, 26'd400, 26'h123};
        run_job(5, 3, 5, 26'd1500, 1'b0);

        // Abort after the first beat with a beat on offer
        start = 1'b1; n_ops = CNT_W'(6);
        tick();
        start = 1'b0;
        send_beat(26'd1, 26'd1, 0);
        op_valid = 1'b1; op_a = 26'd50; op_b = 26'd50; abort = 1'b1;
        #1;
        check("abort_op_ready", 32'(op_ready), 32'd0);
        tick();
        abort = 1'b0; op_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("abort_stays_idle", 32'(res_valid), 32'd0);

        va = '{26'd8}; vb = '{26'd8};
        run_job(2, 0, 0, 26'd16, 1'b0);

        // Maximum job length: 255 ones in 128 beats
        for (int i = 0; i < 128; i++) begin
            va.push_back(26'd1);
            vb.push_back(26'd1);
        end
        run_job(255, 0, 0, 26'd255, 1'b0);

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
